// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Sequences the external VRAM bus and shares it between three requesters:
//   the PPU tile/map fetcher, the OAM DMA source reader and the CPU.
//   Fixed priority PPU > DMA > CPU. Each access takes ACCESS_CYCLES bus cycles.
//   While ppu_lock is high the CPU never reaches the bus. Its reads return 0xFF
//   and its writes are dropped, both acknowledged on the next cycle.
//
// Ports
//   clk, nreset6                       clock (rising edge), async active-low reset
//   ppu_lock                           PPU mode-3 lock, bars the CPU from the bus
//   ppu_req/addr -> ppu_ack/rvalid/rdata   PPU read channel
//   dma_req/addr -> dma_ack/rvalid/rdata   DMA read channel
//   cpu_req/we/addr/wdata -> cpu_ack/rvalid/rdata  CPU read/write channel
//   ma, md_out, md_in, md_oe           VRAM address, write data, read data, data drive
//   mcs_n, moe_n, mwr_n                active-low chip select, output enable, write strobe
//   busy                               high while an access is in progress
module vram_arbiter #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nreset6,
  input  logic              ppu_lock,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ma,
  output logic [DATA_W-1:0] md_out,
  input  logic [DATA_W-1:0] md_in,
  output logic              md_oe,
  output logic              mcs_n,
  output logic              moe_n,
  output logic              mwr_n,
  output logic              busy
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  // With a single-cycle access the write strobe is low from the grant onward.
  localparam logic WR_AT_GRANT = (ACCESS_CYCLES == 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {OWN_PPU, OWN_DMA, OWN_CPU} owner_t;

  state_t            state, state_d;
  owner_t            owner, owner_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              acc_we, acc_we_d;

  logic [ADDR_W-1:0] ma_d;
  logic [DATA_W-1:0] md_out_d;
  logic              md_oe_d, mcs_n_d, moe_n_d, mwr_n_d, busy_d;
  logic              ppu_ack_d, dma_ack_d, cpu_ack_d;
  logic              ppu_rvalid_d, dma_rvalid_d, cpu_rvalid_d;
  logic [DATA_W-1:0] ppu_rdata_d, dma_rdata_d, cpu_rdata_d;

  logic cpu_elig, grant_point, any_elig, lockout;

  assign cpu_elig    = cpu_req && !ppu_lock;
  assign any_elig    = ppu_req || dma_req || cpu_elig;
  assign grant_point = (state == IDLE) || (cnt == '0);
  // Locked-out CPU requests bypass the FSM entirely; !cpu_ack stops a held
  // request from being answered twice in a row.
  assign lockout     = cpu_req && ppu_lock && !cpu_ack;

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    cnt_d        = cnt;
    acc_we_d     = acc_we;
    ma_d         = ma;
    md_out_d     = md_out;
    md_oe_d      = md_oe;
    mcs_n_d      = mcs_n;
    moe_n_d      = moe_n;
    mwr_n_d      = mwr_n;
    busy_d       = busy;
    ppu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    ppu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_rvalid_d = 1'b0;
    ppu_rdata_d  = ppu_rdata;
    dma_rdata_d  = dma_rdata;
    cpu_rdata_d  = cpu_rdata;

    if (state == ACCESS) begin
      if (cnt != '0) begin
        cnt_d   = cnt - 1'b1;
        // Strobe is registered, so assert it on the edge entering cnt==0.
        mwr_n_d = !(acc_we && (cnt == CNT_W'(1)));
      end else begin
        if (!acc_we) begin
          case (owner)
            OWN_PPU: begin ppu_rdata_d = md_in; ppu_rvalid_d = 1'b1; end
            OWN_DMA: begin dma_rdata_d = md_in; dma_rvalid_d = 1'b1; end
            default: begin cpu_rdata_d = md_in; cpu_rvalid_d = 1'b1; end
          endcase
        end
        state_d = IDLE;
        md_oe_d = 1'b0;
        mcs_n_d = 1'b1;
        moe_n_d = 1'b1;
        mwr_n_d = 1'b1;
        busy_d  = 1'b0;
      end
    end

    // A grant here overrides the return to IDLE, giving back-to-back accesses.
    if (grant_point && any_elig) begin
      state_d = ACCESS;
      cnt_d   = CNT_LAST;
      if (ppu_req) begin
        owner_d   = OWN_PPU;
        acc_we_d  = 1'b0;
        ma_d      = ppu_addr;
        ppu_ack_d = 1'b1;
      end else if (dma_req) begin
        owner_d   = OWN_DMA;
        acc_we_d  = 1'b0;
        ma_d      = dma_addr;
        dma_ack_d = 1'b1;
      end else begin
        owner_d   = OWN_CPU;
        acc_we_d  = cpu_we;
        ma_d      = cpu_addr;
        cpu_ack_d = 1'b1;
        if (cpu_we) md_out_d = cpu_wdata;
      end
      md_oe_d = acc_we_d;
      mcs_n_d = 1'b0;
      moe_n_d = acc_we_d;
      mwr_n_d = !(acc_we_d && WR_AT_GRANT);
      busy_d  = 1'b1;
    end

    if (lockout) begin
      cpu_ack_d = 1'b1;
      if (!cpu_we) begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = {DATA_W{1'b1}};
      end
    end
  end

  always_ff @(posedge clk or negedge nreset6) begin
    if (!nreset6) begin
      state      <= IDLE;
      owner      <= OWN_PPU;
      cnt        <= '0;
      acc_we     <= 1'b0;
      ma         <= '0;
      md_out     <= '0;
      md_oe      <= 1'b0;
      mcs_n      <= 1'b1;
      moe_n      <= 1'b1;
      mwr_n      <= 1'b1;
      busy       <= 1'b0;
      ppu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      ppu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      ppu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      acc_we     <= acc_we_d;
      ma         <= ma_d;
      md_out     <= md_out_d;
      md_oe      <= md_oe_d;
      mcs_n      <= mcs_n_d;
      moe_n      <= moe_n_d;
      mwr_n      <= mwr_n_d;
      busy       <= busy_d;
      ppu_ack    <= ppu_ack_d;
      dma_ack    <= dma_ack_d;
      cpu_ack    <= cpu_ack_d;
      ppu_rvalid <= ppu_rvalid_d;
      dma_rvalid <= dma_rvalid_d;
      cpu_rvalid <= cpu_rvalid_d;
      ppu_rdata  <= ppu_rdata_d;
      dma_rdata  <= dma_rdata_d;
      cpu_rdata  <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        nreset6 = 1'b0;
  logic        ppu_lock = 1'b0;
  logic        ppu_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] ppu_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        ppu_ack, ppu_rvalid, dma_ack, dma_rvalid, cpu_ack, cpu_rvalid;
  logic [7:0]  ppu_rdata, dma_rdata, cpu_rdata;
  logic [12:0] ma;
  logic [7:0]  md_out, md_in;
  logic        md_oe, mcs_n, moe_n, mwr_n, busy;
  logic [7:0]  md_drive = 8'h00;

  // single-cycle instance
  logic        ppu_req1 = 1'b0;
  logic [12:0] ppu_addr1 = '0;
  logic        ppu_ack1, ppu_rvalid1, dma_ack1, dma_rvalid1, cpu_ack1, cpu_rvalid1;
  logic [7:0]  ppu_rdata1, dma_rdata1, cpu_rdata1;
  logic [12:0] ma1;
  logic [7:0]  md_out1, md_in1;
  logic        md_oe1, mcs_n1, moe_n1, mwr_n1, busy1;

  int passed = 0;
  int total  = 0;

  // write log of the VRAM model
  int          wr_count = 0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;

  always #5 clk = ~clk;

  assign md_in  = (!mcs_n && !moe_n) ? md_drive : 8'h00;
  assign md_in1 = (!mcs_n1 && !moe_n1) ? 8'h96 : 8'h00;

  always @(posedge clk) begin
    if (!mcs_n && !mwr_n && md_oe) begin
      wr_count <= wr_count + 1;
      wr_addr  <= ma;
      wr_data  <= md_out;
    end
  end

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .ACCESS_CYCLES(2)) u0 (
    .clk(clk), .nreset6(nreset6), .ppu_lock(ppu_lock),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ma(ma), .md_out(md_out), .md_in(md_in), .md_oe(md_oe),
    .mcs_n(mcs_n), .moe_n(moe_n), .mwr_n(mwr_n), .busy(busy)
  );

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .ACCESS_CYCLES(1)) u1 (
    .clk(clk), .nreset6(nreset6), .ppu_lock(1'b0),
    .ppu_req(ppu_req1), .ppu_addr(ppu_addr1), .ppu_ack(ppu_ack1), .ppu_rvalid(ppu_rvalid1), .ppu_rdata(ppu_rdata1),
    .dma_req(1'b0), .dma_addr(13'h0), .dma_ack(dma_ack1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(13'h0), .cpu_wdata(8'h00),
    .cpu_ack(cpu_ack1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .ma(ma1), .md_out(md_out1), .md_in(md_in1), .md_oe(md_oe1),
    .mcs_n(mcs_n1), .moe_n(moe_n1), .mwr_n(mwr_n1), .busy(busy1)
  );

  task automatic test_reset();
    logic [7:0] strobes;
    @(negedge clk);
    strobes = {mcs_n, moe_n, mwr_n, md_oe, busy, ppu_ack, dma_ack, cpu_ack};
    total++; if (strobes !== 8'b1110_0000) $display("FAIL reset_ctrl got=%b exp=11100000", strobes); else passed++;
    total++; if ({ppu_rvalid, dma_rvalid, cpu_rvalid} !== 3'b000) $display("FAIL reset_rvalid got=%b exp=000", {ppu_rvalid, dma_rvalid, cpu_rvalid}); else passed++;
    total++; if ({ppu_rdata, dma_rdata, cpu_rdata} !== 24'h0) $display("FAIL reset_rdata got=%h exp=000000", {ppu_rdata, dma_rdata, cpu_rdata}); else passed++;
    total++; if ({ma, md_out} !== 21'h0) $display("FAIL reset_bus got=%h exp=0", {ma, md_out}); else passed++;
    total++; if ({mcs_n1, busy1} !== 2'b10) $display("FAIL reset_u1 got=%b exp=10", {mcs_n1, busy1}); else passed++;
    nreset6 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; md_drive = 8'h5A;
    @(negedge clk);
    total++; if ({cpu_ack, mcs_n, moe_n, busy, cpu_rvalid} !== 5'b10010) $display("FAIL rd_c1_ctrl got=%b exp=10010", {cpu_ack, mcs_n, moe_n, busy, cpu_rvalid}); else passed++;
    total++; if (ma !== 13'h0123) $display("FAIL rd_c1_ma got=%h exp=0123", ma); else passed++;
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if ({cpu_ack, mcs_n, moe_n, md_oe, cpu_rvalid} !== 5'b00000) $display("FAIL rd_c2_ctrl got=%b exp=00000", {cpu_ack, mcs_n, moe_n, md_oe, cpu_rvalid}); else passed++;
    total++; if (ma !== 13'h0123) $display("FAIL rd_c2_ma got=%h exp=0123", ma); else passed++;
    @(negedge clk);
    total++; if ({cpu_rvalid, mcs_n, moe_n, busy} !== 4'b1110) $display("FAIL rd_done_ctrl got=%b exp=1110", {cpu_rvalid, mcs_n, moe_n, busy}); else passed++;
    total++; if (cpu_rdata !== 8'h5A) $display("FAIL rd_data got=%h exp=5a", cpu_rdata); else passed++;
    @(negedge clk);
    total++; if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h5A}) $display("FAIL rd_hold got=%b/%h exp=0/5a", cpu_rvalid, cpu_rdata); else passed++;
  endtask

  task automatic test_cpu_write();
    int wc0;
    wc0 = wr_count;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hC3;
    @(negedge clk);
    total++; if ({cpu_ack, mcs_n, moe_n, md_oe, mwr_n} !== 5'b10111) $display("FAIL wr_c1_ctrl got=%b exp=10111", {cpu_ack, mcs_n, moe_n, md_oe, mwr_n}); else passed++;
    total++; if ({ma, md_out} !== {13'h1FFF, 8'hC3}) $display("FAIL wr_c1_bus got=%h/%h exp=1fff/c3", ma, md_out); else passed++;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    total++; if ({mcs_n, moe_n, md_oe, mwr_n} !== 4'b0110) $display("FAIL wr_c2_ctrl got=%b exp=0110", {mcs_n, moe_n, md_oe, mwr_n}); else passed++;
    total++; if (md_out !== 8'hC3) $display("FAIL wr_c2_md got=%h exp=c3", md_out); else passed++;
    @(negedge clk);
    total++; if ({cpu_rvalid, mcs_n, mwr_n, md_oe, busy} !== 5'b01100) $display("FAIL wr_done_ctrl got=%b exp=01100", {cpu_rvalid, mcs_n, mwr_n, md_oe, busy}); else passed++;
    total++; if ({wr_count - wc0, wr_addr, wr_data} !== {32'd1, 13'h1FFF, 8'hC3}) $display("FAIL wr_vram got=%0d/%h/%h exp=1/1fff/c3", wr_count - wc0, wr_addr, wr_data); else passed++;
    total++; if (cpu_rdata !== 8'h5A) $display("FAIL wr_rdata_hold got=%h exp=5a", cpu_rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_ma;
    ppu_req = 1'b1; ppu_addr = 13'h0001;
    dma_req = 1'b1; dma_addr = 13'h0002;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0003;
    md_drive = 8'h77;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      total++; if (busy !== (i <= 6)) $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, (i <= 6)); else passed++;
      total++; if ({ppu_ack, dma_ack, cpu_ack} !== {i == 1, i == 3, i == 5}) $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", i, {ppu_ack, dma_ack, cpu_ack}, {i == 1, i == 3, i == 5}); else passed++;
      total++; if ({ppu_rvalid, dma_rvalid, cpu_rvalid} !== {i == 3, i == 5, i == 7}) $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", i, {ppu_rvalid, dma_rvalid, cpu_rvalid}, {i == 3, i == 5, i == 7}); else passed++;
      if (i <= 6) begin
        exp_ma = 13'((i + 1) / 2);
        total++; if (ma !== exp_ma) $display("FAIL b2b_ma cyc=%0d got=%h exp=%h", i, ma, exp_ma); else passed++;
      end
      if (ppu_ack) ppu_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
    end
    total++; if ({ppu_rdata, dma_rdata, cpu_rdata} !== 24'h777777) $display("FAIL b2b_rdata got=%h exp=777777", {ppu_rdata, dma_rdata, cpu_rdata}); else passed++;
    ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lockout();
    int wc0;
    wc0 = wr_count;
    ppu_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0800; md_drive = 8'h11;
    @(negedge clk);
    total++; if ({cpu_ack, cpu_rvalid, mcs_n, busy} !== 4'b1110) $display("FAIL lock_rd_ctrl got=%b exp=1110", {cpu_ack, cpu_rvalid, mcs_n, busy}); else passed++;
    total++; if (cpu_rdata !== 8'hFF) $display("FAIL lock_rd_data got=%h exp=ff", cpu_rdata); else passed++;
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if ({cpu_ack, cpu_rvalid, mcs_n} !== 3'b001) $display("FAIL lock_rd_after got=%b exp=001", {cpu_ack, cpu_rvalid, mcs_n}); else passed++;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0800; cpu_wdata = 8'h99;
    @(negedge clk);
    total++; if ({cpu_ack, cpu_rvalid, mcs_n, md_oe} !== 4'b1010) $display("FAIL lock_wr_ctrl got=%b exp=1010", {cpu_ack, cpu_rvalid, mcs_n, md_oe}); else passed++;
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({wr_count - wc0, mcs_n} !== {32'd0, 1'b1}) $display("FAIL lock_wr_vram got=%0d/%b exp=0/1", wr_count - wc0, mcs_n); else passed++;
    ppu_lock = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    dma_req = 1'b1; dma_addr = 13'h0456; md_drive = 8'h3C;
    @(negedge clk);
    total++; if ({dma_ack, mcs_n, moe_n} !== 3'b100) $display("FAIL rst_pre got=%b exp=100", {dma_ack, mcs_n, moe_n}); else passed++;
    dma_req = 1'b0;
    #1 nreset6 = 1'b0;
    #1;
    total++; if ({mcs_n, moe_n, mwr_n, md_oe, busy, dma_ack} !== 6'b111000) $display("FAIL rst_async got=%b exp=111000", {mcs_n, moe_n, mwr_n, md_oe, busy, dma_ack}); else passed++;
    @(negedge clk);
    @(negedge clk);
    total++; if ({dma_rvalid, dma_rdata} !== 9'h0) $display("FAIL rst_no_rvalid got=%b/%h exp=0/00", dma_rvalid, dma_rdata); else passed++;
    nreset6 = 1'b1;
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 13'h0457;
    @(negedge clk);
    total++; if ({dma_ack, mcs_n, ma} !== {2'b10, 13'h0457}) $display("FAIL rst_fresh_ack got=%b/%b/%h exp=1/0/0457", dma_ack, mcs_n, ma); else passed++;
    dma_req = 1'b0;
    @(negedge clk);
    total++; if (dma_rvalid !== 1'b0) $display("FAIL rst_fresh_early got=%b exp=0", dma_rvalid); else passed++;
    @(negedge clk);
    total++; if ({dma_rvalid, dma_rdata} !== {1'b1, 8'h3C}) $display("FAIL rst_fresh_done got=%b/%h exp=1/3c", dma_rvalid, dma_rdata); else passed++;
  endtask

  task automatic test_single_cycle();
    ppu_req1 = 1'b1; ppu_addr1 = 13'h0AAA;
    @(negedge clk);
    total++; if ({ppu_ack1, mcs_n1, moe_n1, mwr_n1, busy1, ppu_rvalid1} !== 6'b100110) $display("FAIL ac1_c1 got=%b exp=100110", {ppu_ack1, mcs_n1, moe_n1, mwr_n1, busy1, ppu_rvalid1}); else passed++;
    total++; if (ma1 !== 13'h0AAA) $display("FAIL ac1_ma got=%h exp=0aaa", ma1); else passed++;
    ppu_req1 = 1'b0;
    @(negedge clk);
    total++; if ({ppu_rvalid1, mcs_n1, moe_n1, busy1} !== 4'b1110) $display("FAIL ac1_done got=%b exp=1110", {ppu_rvalid1, mcs_n1, moe_n1, busy1}); else passed++;
    total++; if (ppu_rdata1 !== 8'h96) $display("FAIL ac1_data got=%h exp=96", ppu_rdata1); else passed++;
    @(negedge clk);
    total++; if (ppu_rvalid1 !== 1'b0) $display("FAIL ac1_pulse got=%b exp=0", ppu_rvalid1); else passed++;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back();
    test_lockout();
    test_reset_mid_access();
    test_single_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the external VRAM bus (ma/md, chip-select, output-enable and write strobes) and shares it between three requesters: PPU tile/map fetch, OAM DMA source reads, and CPU.
- Sits between the PPU fetcher, the DMA engine, the CPU bus decode and the VRAM pin interface.
- Owns the access timing, fixed-priority arbitration and the mode-3 CPU lockout.

Parameters:
ADDR_W, 13, VRAM address width
DATA_W, 8, VRAM data width
ACCESS_CYCLES, 2, bus cycles per access; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
nreset6  in  1  asynchronous active-low reset
ppu_lock  in  1  PPU mode-3 lock; CPU is barred from the bus while high
ppu_req / ppu_addr  in  1 / ADDR_W  PPU read request and address
ppu_ack / ppu_rvalid  out  1 / 1  PPU accept pulse and read-data-valid pulse
ppu_rdata  out  DATA_W  PPU read data
dma_req / dma_addr  in  1 / ADDR_W  DMA read request and address
dma_ack / dma_rvalid  out  1 / 1  DMA accept pulse and read-data-valid pulse
dma_rdata  out  DATA_W  DMA read data
cpu_req / cpu_we  in  1 / 1  CPU request and write flag
cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data
cpu_ack / cpu_rvalid  out  1 / 1  CPU accept pulse and read-data-valid pulse
cpu_rdata  out  DATA_W  CPU read data
ma  out  ADDR_W  VRAM address
md_out  out  DATA_W  VRAM write data
md_in  in  DATA_W  VRAM read data
md_oe  out  1  drive md_out onto the bus
mcs_n / moe_n / mwr_n  out  1 each  active-low chip select, output enable, write strobe
busy  out  1  high while an access is in progress

Behaviour:
- Reset (async, immediate, also mid-access):
  - state=IDLE; ma=0, md_out=0, md_oe=0; mcs_n=moe_n=mwr_n=1.
  - All *_ack, *_rvalid and busy = 0; all *_rdata = 0x00.
  - Any in-flight access is abandoned: no ack, no rvalid.
- State machine: IDLE, ACCESS. All outputs are registered.
- Eligibility and priority:
  - Eligible requesters are ppu_req, dma_req, and cpu_req && !ppu_lock.
  - Fixed priority is PPU > DMA > CPU. There is no fairness guarantee; continuous PPU requests may starve DMA and CPU.
- Grant, at an edge in IDLE, or at the final edge of ACCESS, with an eligible requester:
  - Latch owner, address, we (PPU and DMA are always reads) and wdata.
  - Pulse the owner's ack for exactly 1 cycle after that edge.
  - Enter ACCESS with cnt=ACCESS_CYCLES-1.
- Back-to-back grants:
  - A grant at the final ACCESS edge starts the next access with no idle bubble.
  - With no eligible requester, the FSM returns to IDLE.
- During ACCESS:
  - busy=1, mcs_n=0, ma holds the latched address, stable for the whole access.
  - Read: moe_n=0, md_oe=0.
  - Write: md_oe=1, md_out=wdata for the whole access; mwr_n=0 only when cnt==0 (the last cycle). With ACCESS_CYCLES=1, mwr_n is low for the whole single cycle.
  - cnt decrements at each edge.
- Completion (edge with cnt==0):
  - Read: owner_rdata<=md_in; owner_rvalid pulses 1 cycle. rdata holds until that owner's next completion.
  - Write: no rvalid.
- Latency: read data is valid exactly ACCESS_CYCLES edges after the grant edge.
- Request rule:
  - A requester must drop req, or present a new address, by the edge ending its access.
  - req still high at a grant point is treated as a new request.
  - Request inputs are not sampled mid-access.
- CPU lockout (cpu_req && ppu_lock && !cpu_ack):
  - Handled at any edge, independent of FSM state.
  - cpu_ack and cpu_rvalid (read only) pulse together next cycle, with cpu_rdata=0xFF.
  - Writes are discarded.
  - There is no bus activity.
- Lock transitions:
  - ppu_lock rising during a granted CPU access: the access completes normally, with no abort.
  - ppu_lock falling: the CPU becomes eligible at the next grant point.
- Simultaneous events: ppu_req, dma_req and cpu_req all high in IDLE → PPU is granted. DMA is granted next if still requesting at the final ACCESS edge, then CPU.

Test Plan:
- Reset, CPU read 0x0123 with md_in=0x5A, ACCESS_CYCLES=2 → cpu_ack 1 cycle after grant edge; mcs_n/moe_n low 2 cycles with ma=0x0123; cpu_rvalid with 0x5A 2 edges after grant.
- CPU write 0x1FFF←0xC3 → md_oe=1 and md_out=0xC3 for 2 cycles; mwr_n low only in the 2nd cycle; no cpu_rvalid.
- ppu_req, dma_req and cpu_req asserted in the same cycle, each held until its ack → grants in order PPU, DMA, CPU, back-to-back with no idle cycle; busy high for 6 consecutive cycles.
- ppu_lock=1, CPU read 0x0800 → cpu_ack and cpu_rvalid next cycle with 0xFF; mcs_n stays 1. CPU write under lock → ack only; VRAM model unchanged.
- nreset6 low in the 1st ACCESS cycle of a DMA read → all strobes 1, md_oe 0, no dma_rvalid. After release, a fresh dma_req completes normally.
- ACCESS_CYCLES=1, PPU read → strobes low 1 cycle; ppu_rvalid 1 edge after grant.
